// File: rtl/mdu_hilo.sv
// Iterative 32x32 multiply unit owning the HI/LO register pair.
// Multiplies take a fixed 33 cycles: 32 shift-add steps plus one write-back cycle.
module mdu_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        mult,
  input  logic        multu,
  input  logic        mtlo,
  input  logic        mthi,
  input  logic        mflo,
  input  logic        mfhi,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        start;
  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic        any_req;

  // Handshake: a request is accepted on the edge where it is high and stall is low;
  // while stall is high the requester must hold the request unchanged.
  assign any_req   = mult | multu | mtlo | mthi | mflo | mfhi;
  assign busy      = (state_q != S_IDLE);
  assign stall     = busy & any_req;
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign rdata     = mflo ? lo_q : (mfhi ? hi_q : 32'd0);

  assign start     = mult | multu;
  assign is_signed = mult;
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign abs_a     = a[31] ? (~a + 32'd1) : a;
  assign abs_b     = b[31] ? (~b + 32'd1) : b;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          mcand_d  = {32'd0, (is_signed ? abs_a : a)};
          mplier_d = is_signed ? abs_b : b;
          neg_d    = is_signed & (a[31] ^ b[31]);
          acc_d    = 64'd0;
          cnt_d    = 6'd0;
        end else begin
          if (mtlo) lo_d = a;
          if (mthi) hi_d = a;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_DONE;
      end
      S_DONE: begin
        state_d      = S_IDLE;
        {hi_d, lo_d} = neg_q ? (~acc_q + 64'd1) : acc_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      neg_q    <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: multiply vectors, HI/LO moves, stall behaviour and reset abort.
module tb_mdu_hilo;

  logic        clk;
  logic        rst;
  logic        mult, multu, mtlo, mthi, mflo, mfhi;
  logic [31:0] a, b;
  logic [31:0] rdata, hi, lo;
  logic        busy, stall, done;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;

  mdu_hilo dut (
    .clk(clk), .rst(rst),
    .mult(mult), .multu(multu), .mtlo(mtlo), .mthi(mthi), .mflo(mflo), .mfhi(mfhi),
    .a(a), .b(b),
    .rdata(rdata), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall), .done(done), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one multiply, scramble operands after the start edge, then check timing and result.
  task automatic run_mul(input string tag, input logic sm, input logic um, input logic ml,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] lo_before, hi_before;
    int cyc, ndone;
    @(negedge clk);
    mult = sm; multu = um; mtlo = ml; a = av; b = bv;
    lo_before = lo; hi_before = hi;
    @(negedge clk);
    mult = 1'b0; multu = 1'b0; mtlo = 1'b0;
    a = $urandom; b = $urandom;
    check({tag, "_lo_hold"}, lo, lo_before);
    check({tag, "_hi_hold"}, hi, hi_before);
    cyc = 0; ndone = 0;
    while (busy && cyc < 100) begin
      if (done) ndone++;
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cyc, 33);
    check({tag, "_done_pulses"}, ndone, 1);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
  endtask

  initial begin
    logic [31:0] lo_before;
    logic        lo_moved;
    int          cyc;
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    mult = 0; multu = 0; mtlo = 0; mthi = 0; mflo = 0; mfhi = 0;
    a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;

    run_mul("multu_3x5",   1'b0, 1'b1, 1'b0, 32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F);
    run_mul("mult_m1x1",   1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mul("mult_min2",   1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_mul("multu_max2",  1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_mul("mult_neg64k", 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000);
    run_mul("both_signed", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // rdata select with hi=FFFFFFFF, lo=FFFFFFFA
    mflo = 1'b1; mfhi = 1'b1; #1;
    check("rdata_both", rdata, 32'hFFFF_FFFA);
    mflo = 1'b0; #1;
    check("rdata_hi", rdata, 32'hFFFF_FFFF);
    mfhi = 1'b0; #1;
    check("rdata_none", rdata, 32'd0);
    check("idle_stall", stall, 1'b0);

    // mthi alone leaves lo untouched
    @(negedge clk);
    mthi = 1'b1; a = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo", lo, 32'hFFFF_FFFA);

    // mtlo held through a running multiply
    @(negedge clk);
    multu = 1'b1; a = 32'd6; b = 32'd7;
    lo_before = lo;
    @(negedge clk);
    multu = 1'b0; mtlo = 1'b1; a = 32'h1234_5678;
    #1;
    check("held_stall", stall, 1'b1);
    lo_moved = 1'b0; cyc = 0;
    while (busy && cyc < 100) begin
      if (lo !== lo_before) lo_moved = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check("held_lo_stable", lo_moved, 1'b0);
    check("held_busy_cycles", cyc, 33);
    check("held_mul_lo", lo, 32'd42);
    #1;
    check("held_stall_low", stall, 1'b0);
    @(negedge clk);
    check("held_mtlo_lo", lo, 32'h1234_5678);
    mtlo = 1'b0; mflo = 1'b1; #1;
    check("held_mflo_rdata", rdata, 32'h1234_5678);
    check("held_mflo_stall", stall, 1'b0);
    mflo = 1'b0;

    // reset in the 10th RUN cycle aborts with no partial write
    @(negedge clk);
    mult = 1'b1; a = 32'd7; b = 32'd9;
    @(negedge clk);
    mult = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_running", busy, 1'b1);
    rst = 1'b1; #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_state", dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b0; mtlo = 1'b1; mthi = 1'b1; a = 32'hA5A5_A5A5;
    @(negedge clk);
    mtlo = 1'b0; mthi = 1'b0;
    check("post_rst_hi", hi, 32'hA5A5_A5A5);
    check("post_rst_lo", lo, 32'hA5A5_A5A5);

    // multiply beats a simultaneous mtlo
    run_mul("mult_mtlo", 1'b1, 1'b0, 1'b1, 32'd2, 32'd7, 32'd0, 32'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
